// File: rtl/rotator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rotator_pkg
//  Purpose  : Shared definitions for the rotation aligner: the FSM state
//             encoding used by rotation_aligner.
//  Contents : IDLE / SEARCH / DONE state codes (2 bits).
//  Revision : 1.0 - initial release
// ============================================================================
package rotator_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

endpackage : rotator_pkg
`default_nettype wire

// File: rtl/rot_left_one.sv
`default_nettype none
// ============================================================================
//  Module   : rot_left_one
//  Purpose  : Purely combinational rotate-left by one bit position.
//  Ports    : i_data [WIDTH-1:0] - word to rotate
//             o_data [WIDTH-1:0] - i_data rotated left by one (MSB -> LSB)
//  Revision : 1.0 - initial release
// ============================================================================
module rot_left_one #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};

endmodule : rot_left_one
`default_nettype wire

// File: rtl/rotation_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : rotation_aligner
//  Purpose  : Finds the smallest rotate-left amount that turns a captured
//             word into a captured target pattern, testing one rotation per
//             clock cycle, and reports the aligned word and the amount.
//  Ports    : clk          - clock, rising edge
//             rst_n        - synchronous active-low reset
//             in_valid     - word/pattern offered
//             in_ready     - block idle, able to accept (decoded from state)
//             data_in      - rotated word to align
//             pattern      - target alignment word
//             out_valid    - result presented
//             out_ready    - consumer takes the result
//             data_aligned - aligned word (original word if no match)
//             SHAMT        - recovered rotate-left amount (0 if no match)
//             found        - a matching rotation exists
//  Revision : 1.0 - initial release
// ============================================================================
module rotation_aligner
    import rotator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [WIDTH-1:0]         pattern,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         data_aligned,
    output logic [$clog2(WIDTH)-1:0] SHAMT,
    output logic                     found
);

    localparam int               c_KW   = $clog2(WIDTH);
    localparam logic [c_KW-1:0]  c_KMAX = c_KW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_pat;
    logic [c_KW-1:0]  r_k;
    logic [WIDTH-1:0] r_aligned;
    logic [c_KW-1:0]  r_shamt;
    logic             r_found;

    logic [WIDTH-1:0] w_rot;
    logic             w_match;
    logic             w_last;

    rot_left_one #(
        .WIDTH (WIDTH)
    ) u_rot (
        .i_data (r_work),
        .o_data (w_rot)
    );

    // Compare only registered copies so no input reaches an output
    // combinationally.
    assign w_match = (r_work == r_pat);
    assign w_last  = (r_k == c_KMAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_work    <= '0;
            r_pat     <= '0;
            r_k       <= '0;
            r_aligned <= '0;
            r_shamt   <= '0;
            r_found   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work  <= data_in;
                        r_pat   <= pattern;
                        r_k     <= '0;
                        r_state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (w_match) begin
                        r_found   <= 1'b1;
                        r_shamt   <= r_k;
                        r_aligned <= r_work;
                        r_state   <= DONE;
                    end else if (w_last) begin
                        // After WIDTH-1 single rotations, one more rotation
                        // restores the originally captured word, so no extra
                        // copy of data_in needs to be kept.
                        r_found   <= 1'b0;
                        r_shamt   <= '0;
                        r_aligned <= w_rot;
                        r_state   <= DONE;
                    end else begin
                        r_work <= w_rot;
                        r_k    <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign data_aligned = r_aligned;
    assign SHAMT        = r_shamt;
    assign found        = r_found;

endmodule : rotation_aligner
`default_nettype wire

// File: doc/rotation_aligner.md
ROTATION_ALIGNER -- requirements
Module: rotation_aligner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width; legal values are powers of two, 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a word and pattern are offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-006 The block SHALL have port data_in, input, WIDTH bits: the rotated word to be aligned.
REQ-007 The block SHALL have port pattern, input, WIDTH bits: the target alignment word.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port data_aligned, output, WIDTH bits: the aligned word.
REQ-011 The block SHALL have port SHAMT, output, $clog2(WIDTH) bits: the recovered rotate-left amount.
REQ-012 The block SHALL have port found, output, 1 bit: high when a matching rotation exists.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SEARCH and DONE.
REQ-014 in_ready SHALL be high only in IDLE; an accept occurs when in_valid and in_ready are both high at a clock edge.
REQ-015 On accept, the block SHALL register data_in into a working register and pattern into a pattern register, clear the step counter k, and enter SEARCH.
REQ-016 In SEARCH, each cycle the block SHALL compare the working register with the pattern register.
  - On no match, it SHALL rotate the working register left by 1 and increment k.
REQ-017 On the first match, the block SHALL enter DONE with found=1, SHAMT=k and data_aligned=working register, so the smallest k is always reported.
REQ-018 If no match occurs at k=WIDTH-1, the block SHALL enter DONE with found=0, SHAMT=0 and data_aligned=the originally captured data_in.
REQ-019 Latency SHALL be k+1 cycles from the accept edge to out_valid high on a match, and WIDTH cycles with no match.
REQ-020 Result semantics: when found=1, rotate-left(data_in, SHAMT) SHALL equal pattern, and rotate-right(pattern, SHAMT) SHALL equal data_in.
REQ-021 out_valid SHALL be high only in DONE; data_aligned, SHAMT and found SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-022 DONE SHALL go to IDLE on the edge where out_valid and out_ready are both high; the next accept is possible on the following edge (one bubble cycle).
REQ-023 in_valid and data_in changes outside IDLE SHALL be ignored; pattern changes after accept SHALL have no effect.
REQ-024 The step counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap within one search.

Reset
REQ-025 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear out_valid, found, SHAMT, data_aligned, the working register, the pattern register and k.
REQ-026 After reset, in_ready SHALL be 1 (IDLE).
REQ-027 Reset during SEARCH or DONE SHALL abort the operation with no result issued, and no partial result SHALL appear after reset is released.

Structure
REQ-028 The state encoding localparams (IDLE=2'd0, SEARCH=2'd1, DONE=2'd2) SHALL live in the shared package rotator_pkg.
REQ-029 The single-step rotate SHALL be a combinational sub-module rot_left_one, parameterized by WIDTH.
REQ-030 The comparison and all outputs SHALL use no combinational path from inputs to outputs, except in_ready, which is decoded from state.

Verification
REQ-031 WIDTH=8, data_in=8'hB4, pattern=8'h4B -> found=1, SHAMT=4, data_aligned=8'h4B, out_valid 5 cycles after accept.
REQ-032 data_in=pattern=8'h3C -> found=1, SHAMT=0 (not 4), out_valid 1 cycle after accept.
REQ-033 data_in=8'h01, pattern=8'h03 -> found=0, SHAMT=0, data_aligned=8'h01, out_valid 8 cycles after accept.
REQ-034 Case of REQ-031 with out_ready held low 3 cycles -> outputs constant, in_ready=0 throughout; after out_ready=1 for one edge -> IDLE, in_ready=1.
REQ-035 rst_n=0 for one edge while SEARCH is at k=2 -> next cycle out_valid=0, all outputs 0, in_ready=1; a new accept completes normally.
REQ-036 Two back-to-back words (8'h80 to pattern 8'h01; then 8'h0F to pattern 8'hF0), out_ready tied high -> SHAMT=1 then SHAMT=4, both with found=1, and one idle bubble between them.
